// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl
//  Brief    : Moore control unit for the 16-register CPU. Fetches a 16-bit
//             instruction into the IR, then sequences the register-file
//             ports, W-data source mux, ALU select and data-memory strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     I_data,
    output logic            I_rd,
    output logic [PC_W-1:0] PC,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [7:0]      RF_W_data,
    output logic [1:0]      RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    input  logic            RF_Rp_zero,
    output logic [1:0]      alu_s
);

    // Opcodes held in IR[15:12]
    localparam logic [3:0] c_OP_LOAD  = 4'b0000;
    localparam logic [3:0] c_OP_STORE = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_LOADC = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0100;
    localparam logic [3:0] c_OP_JMPZ  = 4'b0101;

    // W-data source select and ALU operation codes
    localparam logic [1:0] c_SRC_ALU   = 2'b00;
    localparam logic [1:0] c_SRC_DMEM  = 2'b01;
    localparam logic [1:0] c_SRC_CONST = 2'b10;
    localparam logic [1:0] c_ALU_PASS  = 2'b00;
    localparam logic [1:0] c_ALU_ADD   = 2'b01;
    localparam logic [1:0] c_ALU_SUB   = 2'b10;

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    // Binary-encoded states; encodings 10..15 are unreachable
    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_LOAD     = 4'd3,
        ST_STORE    = 4'd4,
        ST_ADD      = 4'd5,
        ST_SUB      = 4'd6,
        ST_LOADC    = 4'd7,
        ST_JMPZ     = 4'd8,
        ST_JMPZ_JMP = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    logic [3:0]      w_op;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [3:0]      w_rc;
    logic [7:0]      w_imm;
    logic [PC_W-1:0] w_imm_sext;
    logic [PC_W-1:0] w_jmp_target;

    assign w_op  = r_ir[15:12];
    assign w_ra  = r_ir[11:8];
    assign w_rb  = r_ir[7:4];
    assign w_rc  = r_ir[3:0];
    assign w_imm = r_ir[7:0];

    // PC already points one past the JMPZ, so subtract one to land on
    // JMPZ address + signed offset.
    assign w_imm_sext   = {{(PC_W-8){w_imm[7]}}, w_imm};
    assign w_jmp_target = r_pc + w_imm_sext - c_PC_ONE;

    assign PC = r_pc;

    // State, PC and IR registers; reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH) begin
                r_ir <= I_data;
                r_pc <= r_pc + c_PC_ONE;
            end else if (r_state == ST_JMPZ_JMP) begin
                r_pc <= w_jmp_target;
            end
        end
    end

    // Next-state and Moore output decode; everything defaults to zero
    always_comb begin
        w_next     = ST_INIT;
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_W_data  = '0;
        RF_s       = c_SRC_ALU;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Rp_addr = '0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_addr = '0;
        RF_Rq_rd   = 1'b0;
        alu_s      = c_ALU_PASS;

        case (r_state)
            ST_INIT: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                I_rd   = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    c_OP_LOAD:  w_next = ST_LOAD;
                    c_OP_STORE: w_next = ST_STORE;
                    c_OP_ADD:   w_next = ST_ADD;
                    c_OP_LOADC: w_next = ST_LOADC;
                    c_OP_SUB:   w_next = ST_SUB;
                    c_OP_JMPZ:  w_next = ST_JMPZ;
                    default:    w_next = ST_FETCH;
                endcase
            end
            ST_LOAD: begin
                D_addr    = w_imm;
                D_rd      = 1'b1;
                RF_s      = c_SRC_DMEM;
                RF_W_addr = w_ra;
                RF_W_wr   = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_STORE: begin
                D_addr     = w_imm;
                D_wr       = 1'b1;
                RF_Rp_addr = w_ra;
                RF_Rp_rd   = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                RF_Rp_addr = w_rb;
                RF_Rp_rd   = 1'b1;
                RF_Rq_addr = w_rc;
                RF_Rq_rd   = 1'b1;
                alu_s      = (r_state == ST_ADD) ? c_ALU_ADD : c_ALU_SUB;
                RF_s       = c_SRC_ALU;
                RF_W_addr  = w_ra;
                RF_W_wr    = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_LOADC: begin
                RF_W_data = w_imm;
                RF_s      = c_SRC_CONST;
                RF_W_addr = w_ra;
                RF_W_wr   = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_JMPZ: begin
                RF_Rp_addr = w_ra;
                RF_Rp_rd   = 1'b1;
                alu_s      = c_ALU_PASS;
                w_next     = RF_Rp_zero ? ST_JMPZ_JMP : ST_FETCH;
            end
            ST_JMPZ_JMP: begin
                w_next = ST_FETCH;
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

endmodule
`default_nettype wire
